muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit downstream of the register file. Consumes the RD1/RD2 operand pair plus destination index and produces a 32-bit result, destination index and one-cycle write strobe that drive the register file's WD3/A3/WE3 writeback path. The core's control logic stalls while BUSY is high.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
START  in  1  request; accepted only in IDLE
FUNCT3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
OPA  in  XLEN  rs1 value (regfile RD1)
OPB  in  XLEN  rs2 value (regfile RD2)
RD_IN  in  5  destination register index
BUSY  out  1  high whenever state != IDLE
DONE  out  1  one-cycle result-valid and writeback strobe (to WE3)
RESULT  out  XLEN  result (to WD3); held until the next accepted START
RD_OUT  out  5  latched RD_IN (to A3); held with RESULT

Behaviour:
- Interface: single clock clk; reset rst_n asynchronous, active-low.
- Reset: state IDLE, BUSY 0, DONE 0, RESULT 0, RD_OUT 0, counter 0, datapath registers 0. Asserting rst_n low mid-operation aborts immediately. No DONE is issued for the aborted operation.
- States: IDLE, MUL, DIV, DONE.
- IDLE, START=1 at edge E: latch FUNCT3, RD_IN, operand magnitudes and result-sign flags. Signedness per FUNCT3: MULH both signed; MULHSU OPA signed, OPB unsigned; MULHU/DIVU/REMU unsigned; DIV/REM signed. Next state is MUL (FUNCT3[2]=0) or DIV (FUNCT3[2]=1). Counter is cleared.
- MUL: shift-add, one bit of the multiplier per cycle into a 64-bit product accumulator. After 32 iterations (edges E+1..E+32), the final sign correction is applied (two's-complement negate of the 64-bit product if the sign flags differ). At edge E+33, state becomes DONE. RESULT is product[31:0] for MUL and product[63:32] otherwise.
- DIV: restoring division, one quotient bit per cycle, 32 iterations. At edge E+33, state becomes DONE. The quotient is negated if the signed dividend and divisor signs differ. The remainder takes the sign of the dividend.
- Special cases, resolved at acceptance:
  - OPB=0: next state is DONE directly at edge E+1. DIV/DIVU result 0xFFFFFFFF. REM/REMU result OPA.
  - Signed overflow (OPA=0x80000000, OPB=0xFFFFFFFF, DIV/REM): next state is DONE at edge E+1. DIV result 0x80000000. REM result 0.
- DONE: DONE=1 for exactly one cycle, then IDLE. START is ignored in DONE and in every non-IDLE state. A START asserted during DONE is not queued.
- RESULT and RD_OUT update only on entry to DONE.
- Total latency START→DONE: 33 cycles iterative, 1 cycle special case.
- Operand inputs are sampled only at acceptance and may change afterwards.

Optional Feature:
MULDIV_FAST_MUL_EN:
- Defined: MUL-class ops compute the full 64-bit product in one cycle with the synthesis multiplier. IDLE→DONE at edge E+1, and the MUL state is unused. Division is unchanged.
- Undefined: iterative 33-cycle multiply as described above.

Decomposition:
- Shared package (muldiv_pkg): FUNCT3 encodings as named constants, state encoding, XLEN, and the constants 0xFFFFFFFF/0x80000000 used for special results.
- One natural sub-module, muldiv_sign_fix: combinational magnitude extraction and result negation. It is instantiated for the operand-in and result-out paths.
- FSM, counter and shift registers stay in muldiv_unit.

Test Plan:
- MUL 7 × −3 (OPB=0xFFFFFFFD), RD_IN=5 → BUSY for 33 cycles, DONE one cycle, RESULT 0xFFFFFFEB, RD_OUT 5; MULHU same operands → 0x00000006.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → DONE at cycle 1, RESULT 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 at cycle 1; REM of the same operands → 0.
- START pulsed at cycles 3, 10 and 33 of an operation, with different operands → ignored. Only one DONE is issued; RESULT is from the first request.
- rst_n pulsed low at cycle 15 of a DIV → BUSY/DONE/RESULT 0 immediately, no DONE follows. A new MUL 3×4 afterwards → RESULT 12. Repeat with MULDIV_FAST_MUL_EN defined → DONE one cycle after START.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: widths, FUNCT3
// encodings, FSM states and the fixed special-case result constants.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation: turns signed operands into
// magnitudes and applies the final sign to products, quotients and remainders.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + 1'b1) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply using the synthesis multiplier.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OPA,
    input  logic [XLEN-1:0] OPB,
    input  logic [4:0]      RD_IN,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT,
    output logic [4:0]      RD_OUT
);

    localparam logic [CNT_W-1:0] ITERS = CNT_W'(XLEN);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2*XLEN-1:0]   prod;      // product, or {remainder, quotient} when dividing
    logic [XLEN-1:0]     mcand;     // multiplicand, or divisor
    logic [2:0]          f3;
    logic [4:0]          rd_q;
    logic                q_neg, r_neg, early_q;
    logic [XLEN-1:0]     early_res_q;

    logic                a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_zero, overflow, early;
    logic [XLEN-1:0]     early_res;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (FUNCT3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            F3_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
    end

    assign neg_a = a_signed & OPA[XLEN-1];
    assign neg_b = b_signed & OPB[XLEN-1];

    muldiv_sign_fix #(.W(XLEN)) u_mag_a (.val(OPA), .neg(neg_a), .res(mag_a));
    muldiv_sign_fix #(.W(XLEN)) u_mag_b (.val(OPB), .neg(neg_b), .res(mag_b));

    assign div_zero = FUNCT3[2] && (OPB == '0);
    assign overflow = ((FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM)) &&
                      (OPA == INT_MIN) && (OPB == ALL_ONES);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] ext_a, ext_b;
    logic        [2*XLEN-1:0] fast_prod;

    assign ext_a     = {{XLEN{neg_a}}, OPA};
    assign ext_b     = {{XLEN{neg_b}}, OPB};
    assign fast_prod = ext_a * ext_b;
    assign early     = div_zero | overflow | ~FUNCT3[2];
`else
    assign early     = div_zero | overflow;
`endif

    always_comb begin
        early_res = '0;
        if (div_zero)
            early_res = FUNCT3[1] ? OPA : ALL_ONES;
        else if (overflow)
            early_res = FUNCT3[1] ? '0 : INT_MIN;
`ifdef MULDIV_FAST_MUL_EN
        else if (!FUNCT3[2])
            early_res = (FUNCT3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif
    end

    logic [XLEN:0]       mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0]   mul_next, div_next;

    assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    assign mul_next = {mul_sum, prod[XLEN-1:1]};

    // A borrow out of the trial subtraction means the divisor did not fit.
    assign div_sh   = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    assign div_diff = div_sh - {1'b0, mcand};
    assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0],   prod[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0]   prod_fixed;
    logic [XLEN-1:0]     quo_fixed, rem_fixed, mul_res, div_res;

    muldiv_sign_fix #(.W(2*XLEN)) u_prod_fix (.val(prod), .neg(q_neg), .res(prod_fixed));
    muldiv_sign_fix #(.W(XLEN)) u_quo_fix (.val(prod[XLEN-1:0]), .neg(q_neg), .res(quo_fixed));
    muldiv_sign_fix #(.W(XLEN)) u_rem_fix (.val(prod[2*XLEN-1:XLEN]), .neg(r_neg), .res(rem_fixed));

    assign mul_res = (f3 == F3_MUL) ? prod_fixed[XLEN-1:0] : prod_fixed[2*XLEN-1:XLEN];
    assign div_res = f3[1] ? rem_fixed : quo_fixed;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            RESULT      <= '0;
            RD_OUT      <= '0;
            cnt         <= '0;
            prod        <= '0;
            mcand       <= '0;
            f3          <= '0;
            rd_q        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            early_q     <= 1'b0;
            early_res_q <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: if (START) begin
                    f3          <= FUNCT3;
                    rd_q        <= RD_IN;
                    q_neg       <= neg_a ^ neg_b;
                    r_neg       <= neg_a;
                    cnt         <= '0;
                    early_q     <= early;
                    early_res_q <= early_res;
                    BUSY        <= 1'b1;
                    if (FUNCT3[2]) begin
                        prod  <= {{XLEN{1'b0}}, mag_a};
                        mcand <= mag_b;
                    end else begin
                        prod  <= {{XLEN{1'b0}}, mag_b};
                        mcand <= mag_a;
                    end
                    // One-cycle results wait in DIV for a single edge before DONE.
                    state <= (FUNCT3[2] || early) ? S_DIV : S_MUL;
                end
                S_MUL, S_DIV: begin
                    if (early_q || cnt == ITERS) begin
                        state  <= S_DONE;
                        DONE   <= 1'b1;
                        RESULT <= early_q ? early_res_q : ((state == S_MUL) ? mul_res : div_res);
                        RD_OUT <= rd_q;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        prod <= (state == S_MUL) ? mul_next : div_next;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
